// File: rtl/leaf_quad_pkg.sv
// rtl/leaf_quad_pkg.sv - shared widths, leaf index type and arbiter state encoding
package leaf_quad_pkg;

    localparam int PKT_W      = 49;
    localparam int VALID_BIT  = 48;
    localparam int PAY_W      = 48;
    localparam int NUM_LEAF   = 4;

    typedef logic [1:0] leaf_idx_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_t;

    // Leaf index 'step' positions after 'base', wrapping over the four leaves.
    function automatic leaf_idx_t rr_offset(input leaf_idx_t base, input int step);
        return base + leaf_idx_t'(step);
    endfunction

endpackage

// File: rtl/leaf_pkt_fifo.sv
// rtl/leaf_pkt_fifo.sv - per-leaf synchronous packet FIFO with show-ahead read data
module leaf_pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers and occupancy; the caller only pushes when space exists after a same-edge pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/leaf_quad_egress_arb.sv
// rtl/leaf_quad_egress_arb.sv - four-leaf round-robin egress merge to BFT; optional LEAF_QUAD_ARB_STATS_EN grant counters
module leaf_quad_egress_arb
    import leaf_quad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                clk_400,
    input  logic                reset_400,
    input  logic [PKT_W-1:0]    din_leaf_interface2arb_0,
    input  logic [PKT_W-1:0]    din_leaf_interface2arb_1,
    input  logic [PKT_W-1:0]    din_leaf_interface2arb_2,
    input  logic [PKT_W-1:0]    din_leaf_interface2arb_3,
    output logic                resend_0,
    output logic                resend_1,
    output logic                resend_2,
    output logic                resend_3,
    output logic [PKT_W-1:0]    dout_arb2bft,
    input  logic                resend_bft,
    output logic [NUM_LEAF-1:0] ovf
`ifdef LEAF_QUAD_ARB_STATS_EN
    ,
    output logic [15:0]         grant_cnt_0,
    output logic [15:0]         grant_cnt_1,
    output logic [15:0]         grant_cnt_2,
    output logic [15:0]         grant_cnt_3
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_CNT = CW'(AF_THRESH);

    logic [PKT_W-1:0]    din [NUM_LEAF];
    logic [PAY_W-1:0]    rdata [NUM_LEAF];
    logic [CW-1:0]       count [NUM_LEAF];
    logic [CW-1:0]       occ_next [NUM_LEAF];
    logic [NUM_LEAF-1:0] push, pop, drop, full, empty;
    logic [NUM_LEAF-1:0] resend_q;
    logic [PAY_W-1:0]    payload_q;
    leaf_idx_t           last_grant, grant_idx;
    logic                grant_valid;
    arb_state_t          state, state_next;

    assign din[0] = din_leaf_interface2arb_0;
    assign din[1] = din_leaf_interface2arb_1;
    assign din[2] = din_leaf_interface2arb_2;
    assign din[3] = din_leaf_interface2arb_3;

    for (genvar g = 0; g < NUM_LEAF; g++) begin : g_leaf
        leaf_pkt_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (PAY_W)
        ) u_fifo (
            .clk   (clk_400),
            .rst   (reset_400),
            .push  (push[g]),
            .pop   (pop[g]),
            .wdata (din[g][PAY_W-1:0]),
            .rdata (rdata[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g])
        );
    end

    // Round-robin search: first non-empty leaf after the last one granted.
    always_comb begin
        leaf_idx_t cand;
        cand        = last_grant;
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        for (int i = 1; i <= NUM_LEAF; i++) begin
            cand = rr_offset(last_grant, i);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant only turns into a pop when the BFT is not stalling us.
    always_comb begin
        pop = '0;
        for (int n = 0; n < NUM_LEAF; n++) begin
            pop[n] = !resend_bft && grant_valid && (grant_idx == leaf_idx_t'(n));
        end
    end

    // Accept input when space exists after any same-edge pop, otherwise drop it; track next occupancy.
    always_comb begin
        push     = '0;
        drop     = '0;
        occ_next = '{default: '0};
        for (int n = 0; n < NUM_LEAF; n++) begin
            push[n]     = din[n][VALID_BIT] && (!full[n] || pop[n]);
            drop[n]     = din[n][VALID_BIT] && full[n] && !pop[n];
            occ_next[n] = count[n] + CW'(push[n]) - CW'(pop[n]);
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) state <= ARB_IDLE;
        else           state <= state_next;
    end

    // Next state: SEND while a packet is being presented, frozen during BFT stall.
    always_comb begin
        state_next = state;
        if (!resend_bft) begin
            state_next = grant_valid ? ARB_SEND : ARB_IDLE;
        end
    end

    // Output payload and last grant; both frozen while the BFT stalls.
    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            payload_q  <= '0;
            last_grant <= leaf_idx_t'(NUM_LEAF - 1);
        end else if (!resend_bft) begin
            payload_q <= grant_valid ? rdata[grant_idx] : '0;
            if (grant_valid) last_grant <= grant_idx;
        end
    end

    assign dout_arb2bft = {(state == ARB_SEND), payload_q};

    // Leaf backpressure from post-edge occupancy, and sticky overflow flags.
    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            resend_q <= '0;
            ovf      <= '0;
        end else begin
            for (int n = 0; n < NUM_LEAF; n++) begin
                resend_q[n] <= (occ_next[n] >= AF_CNT);
            end
            ovf <= ovf | drop;
        end
    end

    assign resend_0 = resend_q[0];
    assign resend_1 = resend_q[1];
    assign resend_2 = resend_q[2];
    assign resend_3 = resend_q[3];

`ifdef LEAF_QUAD_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_LEAF];

    // Per-leaf saturating grant counters.
    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            grant_cnt <= '{default: '0};
        end else begin
            for (int n = 0; n < NUM_LEAF; n++) begin
                if (pop[n] && (grant_cnt[n] != 16'hFFFF)) grant_cnt[n] <= grant_cnt[n] + 16'd1;
            end
        end
    end

    assign grant_cnt_0 = grant_cnt[0];
    assign grant_cnt_1 = grant_cnt[1];
    assign grant_cnt_2 = grant_cnt[2];
    assign grant_cnt_3 = grant_cnt[3];
`endif

endmodule

// File: tb/tb_leaf_quad_egress_arb.sv
// tb/tb_leaf_quad_egress_arb.sv - directed vector bench for leaf_quad_egress_arb (LEAF_QUAD_ARB_STATS_EN adds counter checks)
module tb_leaf_quad_egress_arb;

    logic        clk_400 = 1'b0;
    logic        reset_400 = 1'b0;
    logic [48:0] din0, din1, din2, din3;
    logic        resend_bft;
    logic        resend_0, resend_1, resend_2, resend_3;
    logic [48:0] dout_arb2bft;
    logic [3:0]  ovf;
`ifdef LEAF_QUAD_ARB_STATS_EN
    logic [15:0] grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  tag;
        logic        rb;
        logic [48:0] dout;
        logic [3:0]  rs;
        logic [3:0]  ov;
    } vec_t;

    vec_t tbl[$];

    leaf_quad_egress_arb dut (
        .clk_400                  (clk_400),
        .reset_400                (reset_400),
        .din_leaf_interface2arb_0 (din0),
        .din_leaf_interface2arb_1 (din1),
        .din_leaf_interface2arb_2 (din2),
        .din_leaf_interface2arb_3 (din3),
        .resend_0                 (resend_0),
        .resend_1                 (resend_1),
        .resend_2                 (resend_2),
        .resend_3                 (resend_3),
        .dout_arb2bft             (dout_arb2bft),
        .resend_bft               (resend_bft),
        .ovf                      (ovf)
`ifdef LEAF_QUAD_ARB_STATS_EN
        ,
        .grant_cnt_0              (grant_cnt_0),
        .grant_cnt_1              (grant_cnt_1),
        .grant_cnt_2              (grant_cnt_2),
        .grant_cnt_3              (grant_cnt_3)
`endif
    );

    always #5 clk_400 = ~clk_400;

    function automatic logic [47:0] pl(input int n, input logic [7:0] tag);
        return {36'h0, 4'(n), tag};
    endfunction

    function automatic logic [48:0] dv(input int n, input logic [7:0] tag);
        return {1'b1, pl(n, tag)};
    endfunction

    function automatic logic [3:0] rs_vec();
        return {resend_3, resend_2, resend_1, resend_0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_400);
        #1;
    endtask

    task automatic set_din(input logic [3:0] v, input logic [7:0] tag);
        din0 = {v[0], pl(0, tag)};
        din1 = {v[1], pl(1, tag)};
        din2 = {v[2], pl(2, tag)};
        din3 = {v[3], pl(3, tag)};
    endtask

    task automatic do_reset();
        set_din(4'h0, 8'h00);
        resend_bft = 1'b0;
        reset_400  = 1'b1;
        tick();
        tick();
        reset_400 = 1'b0;
    endtask

    initial begin
        set_din(4'h0, 8'h00);
        resend_bft = 1'b0;
        #1;
        reset_400 = 1'b1;
        tick();
        chk("reset dout", 64'(dout_arb2bft), 64'h0);
        chk("reset resend", 64'(rs_vec()), 64'h0);
        chk("reset ovf", 64'(ovf), 64'h0);
        tick();
        reset_400 = 1'b0;

        // All leaves push four packets, then drain in 0,1,2,3 order; then leaf 0 overflow under stall.
        tbl.push_back('{4'hF, 8'h01, 1'b0, 49'h0,        4'h0, 4'h0});
        tbl.push_back('{4'hF, 8'h02, 1'b0, dv(0, 8'h01), 4'h0, 4'h0});
        tbl.push_back('{4'hF, 8'h03, 1'b0, dv(1, 8'h01), 4'hC, 4'h0});
        tbl.push_back('{4'hF, 8'h04, 1'b0, dv(2, 8'h01), 4'hF, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(3, 8'h01), 4'hF, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h02), 4'hE, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(1, 8'h02), 4'hC, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(2, 8'h02), 4'h8, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(3, 8'h02), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h03), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(1, 8'h03), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(2, 8'h03), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(3, 8'h03), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h04), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(1, 8'h04), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(2, 8'h04), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(3, 8'h04), 4'h0, 4'h0});
        tbl.push_back('{4'h0, 8'h00, 1'b0, 49'h0,        4'h0, 4'h0});
        tbl.push_back('{4'h1, 8'h11, 1'b1, 49'h0,        4'h0, 4'h0});
        tbl.push_back('{4'h1, 8'h12, 1'b1, 49'h0,        4'h0, 4'h0});
        tbl.push_back('{4'h1, 8'h13, 1'b1, 49'h0,        4'h1, 4'h0});
        tbl.push_back('{4'h1, 8'h14, 1'b1, 49'h0,        4'h1, 4'h0});
        tbl.push_back('{4'h1, 8'h15, 1'b1, 49'h0,        4'h1, 4'h1});
        tbl.push_back('{4'h1, 8'h16, 1'b0, dv(0, 8'h11), 4'h1, 4'h1});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h12), 4'h1, 4'h1});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h13), 4'h0, 4'h1});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h14), 4'h0, 4'h1});
        tbl.push_back('{4'h0, 8'h00, 1'b0, dv(0, 8'h16), 4'h0, 4'h1});
        tbl.push_back('{4'h0, 8'h00, 1'b0, 49'h0,        4'h0, 4'h1});

        for (int i = 0; i < tbl.size(); i++) begin
            set_din(tbl[i].v, tbl[i].tag);
            resend_bft = tbl[i].rb;
            tick();
            chk($sformatf("row%0d dout", i), 64'(dout_arb2bft), 64'(tbl[i].dout));
            chk($sformatf("row%0d resend", i), 64'(rs_vec()), 64'(tbl[i].rs));
            chk($sformatf("row%0d ovf", i), 64'(ovf), 64'(tbl[i].ov));
        end

        // Reset pulse with three packets buffered on leaf 3 and a packet on dout.
        set_din(4'h0, 8'h00);
        din1 = {1'b1, pl(1, 8'h41)};
        resend_bft = 1'b0;
        tick();
        chk("rst seq push", 64'(dout_arb2bft), 64'h0);
        set_din(4'h0, 8'h00);
        tick();
        chk("rst seq grant", 64'(dout_arb2bft), 64'(dv(1, 8'h41)));
        resend_bft = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din3 = {1'b1, pl(3, 8'(8'h51 + i))};
            tick();
            chk($sformatf("rst seq hold%0d", i), 64'(dout_arb2bft), 64'(dv(1, 8'h41)));
        end
        chk("rst seq resend3", 64'(rs_vec()), 64'h8);
        set_din(4'h0, 8'h00);
        #2;
        reset_400 = 1'b1;
        #1;
        chk("async rst dout", 64'(dout_arb2bft), 64'h0);
        chk("async rst resend", 64'(rs_vec()), 64'h0);
        chk("async rst ovf", 64'(ovf), 64'h0);
        tick();
        reset_400  = 1'b0;
        resend_bft = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post rst idle%0d", i), 64'(dout_arb2bft), 64'h0);
        end

        // Single 0xA5 on leaf 2: out one edge after it is sampled, then back to zero.
        din2 = {1'b1, 48'hA5};
        tick();
        chk("a5 sample edge", 64'(dout_arb2bft), 64'h0);
        din2 = '0;
        tick();
        chk("a5 out", 64'(dout_arb2bft), 64'(49'h1_0000_0000_00A5));
        tick();
        chk("a5 after", 64'(dout_arb2bft), 64'h0);

        // Five-cycle BFT stall with packets queued; resumes at the next leaf in order.
        do_reset();
        set_din(4'h7, 8'h21);
        tick();
        chk("stall fill", 64'(dout_arb2bft), 64'h0);
        set_din(4'h0, 8'h00);
        tick();
        chk("stall first", 64'(dout_arb2bft), 64'(dv(0, 8'h21)));
        resend_bft = 1'b1;
        din0 = {1'b1, pl(0, 8'h33)};
        for (int i = 0; i < 5; i++) begin
            tick();
            din0 = '0;
            chk($sformatf("stall hold%0d", i), 64'(dout_arb2bft), 64'(dv(0, 8'h21)));
        end
        resend_bft = 1'b0;
        tick();
        chk("resume leaf1", 64'(dout_arb2bft), 64'(dv(1, 8'h21)));
        tick();
        chk("resume leaf2", 64'(dout_arb2bft), 64'(dv(2, 8'h21)));
        tick();
        chk("resume leaf0", 64'(dout_arb2bft), 64'(dv(0, 8'h33)));
        tick();
        chk("resume drained", 64'(dout_arb2bft), 64'h0);

`ifdef LEAF_QUAD_ARB_STATS_EN
        // Lone requester on leaf 1 is granted every cycle until the counter saturates.
        do_reset();
        din1 = {1'b1, pl(1, 8'h77)};
        for (int i = 0; i < 10; i++) tick();
        chk("cnt1 early", 64'(grant_cnt_1), 64'd9);
        for (int i = 0; i < 70000; i++) tick();
        chk("cnt1 sat", 64'(grant_cnt_1), 64'hFFFF);
        chk("cnt0", 64'(grant_cnt_0), 64'h0);
        chk("cnt2", 64'(grant_cnt_2), 64'h0);
        chk("cnt3", 64'(grant_cnt_3), 64'h0);
        din1 = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_quad_egress_arb.md
LEAF_QUAD_EGRESS_ARB -- requirements
Module: leaf_quad_egress_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, per-leaf packet buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter AF_THRESH, default 3, FIFO occupancy at or above which that leaf's resend asserts.
REQ-003 SHALL have port clk_400  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset_400  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports din_leaf_interface2arb_0..3  in  49 each  leaf packets; bit 48 = valid, [47:0] = payload.
REQ-006 SHALL have ports resend_0..3  out  1 each  backpressure to leaf N.
REQ-007 SHALL have port dout_arb2bft  out  49  merged packet to BFT; bit 48 = valid.
REQ-008 SHALL have port resend_bft  in  1  upstream stall from BFT.
REQ-009 SHALL have port ovf  out  4  sticky per-leaf overflow flags.

Function
REQ-010 SHALL write din_N[47:0] into FIFO N on any edge where din_N[48]=1 and FIFO N is not full after same-edge pop.
REQ-011 SHALL, on a full FIFO N with valid input and no same-edge pop, drop the packet and set ovf[N].
REQ-012 SHALL accept simultaneous push and pop on one FIFO, occupancy unchanged, including when full.
REQ-013 SHALL register resend_N = (occupancy_N >= AF_THRESH), updated every edge.
REQ-014 SHALL, on each edge with resend_bft=0, grant the first non-empty FIFO in round-robin order starting at (last_grant+1) mod 4, pop it and register {1'b1, payload} onto dout_arb2bft.
REQ-015 SHALL drive dout_arb2bft = 49'b0 after an edge with resend_bft=0 and all FIFOs empty.
REQ-016 SHALL, on an edge with resend_bft=1, hold dout_arb2bft unchanged, pop nothing, and leave last_grant unchanged.
REQ-017 SHALL update last_grant only on a granted pop; a lone requester is granted every cycle.
REQ-018 SHALL have latency: packet sampled into empty FIFO on edge k, arbiter idle, appears on dout_arb2bft after edge k+1.
REQ-019 SHALL preserve per-leaf packet order; no packet duplicated or lost except REQ-011 drops.
REQ-020 SHALL implement the arbiter as two states, IDLE (no output valid) and SEND (output valid); IDLE->SEND on grant, SEND->IDLE on empty with resend_bft=0, SEND held while resend_bft=1.

Reset
REQ-021 SHALL, while reset_400=1, force dout_arb2bft=0, resend_0..3=0, ovf=0, all FIFO occupancies 0, last_grant=3 (first grant is leaf 0), state IDLE.
REQ-022 SHALL discard all buffered packets on reset asserted mid-operation; no packet emitted after reset release without a new input.

Configuration
REQ-023 SHALL, with macro LEAF_QUAD_ARB_STATS_EN defined, add outputs grant_cnt_0..3 (16 bits each), incremented per grant, saturating at 16'hFFFF, reset to 0.
REQ-024 SHALL, without LEAF_QUAD_ARB_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-025 SHALL place PKT_W=49, VALID_BIT=48, NUM_LEAF=4 and the arbiter state enum in shared package leaf_quad_pkg.
REQ-026 SHALL instantiate four copies of sub-module leaf_pkt_fifo (synchronous FIFO with push, pop, full, empty, count).

Verification
REQ-027 SHALL cover: single packet 0xA5 on leaf 2 at edge 10, others idle -> dout_arb2bft = {1,0xA5} after edge 11, then 0.
REQ-028 SHALL cover: all four leaves valid continuously from reset release -> grant order 0,1,2,3,0,... one per cycle, no gaps.
REQ-029 SHALL cover: resend_bft=1 for 5 cycles with packets queued -> dout held constant 5 cycles; resumes at next round-robin leaf.
REQ-030 SHALL cover: resend_bft=1, 5 packets into leaf 0 -> resend_0 high after 3rd push, 5th dropped, ovf[0]=1, 4 packets later emitted in order.
REQ-031 SHALL cover: reset_400 pulsed while 3 packets buffered -> dout 0 immediately, those packets never emitted, ovf cleared.
REQ-032 SHALL cover (stats build): 70000 grants on leaf 1 -> grant_cnt_1 = 16'hFFFF, others 0.
